// File: rtl/delay_line_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_if
// Description : Sample/control bundle between a producer and delay_line.
//               The master drives samples and control. The slave (delay_line)
//               returns the delayed sample and its status.
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_line_if #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
);
  logic               en;
  logic               load;
  logic [A_WIDTH-1:0] delay;
  logic [2:0]         fb_shift;
  logic [D_WIDTH-1:0] mic_signal;
  logic [D_WIDTH-1:0] delayed_signal;
  logic               out_valid;
  logic               primed;

  modport master (
    output en, load, delay, fb_shift, mic_signal,
    input  delayed_signal, out_valid, primed
  );

  modport slave (
    input  en, load, delay, fb_shift, mic_signal,
    output delayed_signal, out_valid, primed
  );
endinterface
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module      : delay_line
// Description : Programmable sample delay over a circular buffer of
//               2^A_WIDTH offset-binary samples. A FILL phase emits the
//               midpoint until delay_q samples are stored. RUN then emits each
//               sample delayed by delay_q strobes.
//               Optional macro ECHO_FEEDBACK_EN mixes an attenuated copy of
//               the delayed sample back into the buffer. The mix saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  delay_line_if.slave  bus
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [D_WIDTH-1:0] MID   = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [A_WIDTH-1:0] A_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  state_t             state_q,    state_d;
  logic [A_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [A_WIDTH-1:0] delay_q,    delay_d;
  logic [A_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [D_WIDTH-1:0] delayed_q,  delayed_d;
  logic               out_valid_q;
  logic               primed_q;

  logic [A_WIDTH-1:0] rd_addr;
  logic [D_WIDTH-1:0] rd_data;
  logic [D_WIDTH-1:0] wr_data;

  // The subtraction wraps naturally in A_WIDTH bits.
  assign rd_addr = wr_addr_q - delay_q;
  assign rd_data = mem_q[rd_addr];

`ifdef ECHO_FEEDBACK_EN
  localparam int S_WIDTH = D_WIDTH + 2;
  localparam logic signed [S_WIDTH-1:0] S_MID = {2'b00, MID};
  localparam logic signed [S_WIDTH-1:0] S_MAX = {2'b00, {D_WIDTH{1'b1}}};

  logic                      fb_on;
  logic signed [S_WIDTH-1:0] fb_term;
  logic signed [S_WIDTH-1:0] fb_sum;

  // Add the attenuated echo to the input sample and clamp it to the sample range.
  // Feedback is active only when the read location holds a real sample.
  always_comb begin
    fb_on   = (state_q == RUN) && !bus.load && (delay_q != '0) && (bus.fb_shift != 3'd0);
    fb_term = ($signed({2'b00, rd_data}) - S_MID) >>> bus.fb_shift;
    fb_sum  = $signed({2'b00, bus.mic_signal}) + fb_term;
    wr_data = bus.mic_signal;
    if (fb_on) begin
      if (fb_sum < 0)
        wr_data = '0;
      else if (fb_sum > S_MAX)
        wr_data = '1;
      else
        wr_data = fb_sum[D_WIDTH-1:0];
    end
  end
`else
  logic [2:0] unused_fb_shift;
  assign unused_fb_shift = bus.fb_shift;
  assign wr_data         = bus.mic_signal;
`endif

  // Next-state logic: the write pointer, the delay latch, fill counting and output selection.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    delay_d    = delay_q;
    fill_cnt_d = fill_cnt_q;
    delayed_d  = delayed_q;

    if (bus.en)
      wr_addr_d = wr_addr_q + A_ONE;

    if (bus.load) begin
      // A sample that arrives with load counts as the first fill sample.
      delay_d    = bus.delay;
      fill_cnt_d = {{(A_WIDTH-1){1'b0}}, bus.en};
      state_d    = FILL;
      if (bus.en)
        delayed_d = MID;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.en) begin
            fill_cnt_d = fill_cnt_q + A_ONE;
            delayed_d  = MID;
          end
          // Compare against the updated count so that RUN starts right after the last fill sample.
          if ((delay_q == '0) || (fill_cnt_d == delay_q))
            state_d = RUN;
        end
        RUN: begin
          if (bus.en)
            delayed_d = (delay_q == '0) ? wr_data : rd_data;
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State and output registers. Reset discards any priming progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_addr_q   <= '0;
      delay_q     <= '0;
      fill_cnt_q  <= '0;
      delayed_q   <= MID;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      delay_q     <= delay_d;
      fill_cnt_q  <= fill_cnt_d;
      delayed_q   <= delayed_d;
      out_valid_q <= bus.en;
      primed_q    <= (state_d == RUN);
    end
  end

  // Sample buffer write. Its contents are never cleared.
  always_ff @(posedge clk) begin
    if (rst && bus.en)
      mem_q[wr_addr_q] <= wr_data;
  end

  assign bus.delayed_signal = delayed_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.primed         = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_line
// Description : Directed, self-checking bench for delay_line. It uses a
//               default-size instance and an A_WIDTH=3 instance for the
//               wrap-around case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_line_if #(.A_WIDTH(9), .D_WIDTH(8)) bus9 ();
  delay_line_if #(.A_WIDTH(3), .D_WIDTH(8)) bus3 ();

  delay_line #(.A_WIDTH(9), .D_WIDTH(8)) dut9 (
    .clk (clk),
    .rst (rst),
    .bus (bus9)
  );

  delay_line #(.A_WIDTH(3), .D_WIDTH(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus to the 9-bit instance. Outputs settle 1 time unit after the edge.
  task automatic cyc9(input logic en, input logic load, input logic [8:0] dly,
                      input logic [2:0] fb, input logic [7:0] mic);
    bus9.en         = en;
    bus9.load       = load;
    bus9.delay      = dly;
    bus9.fb_shift   = fb;
    bus9.mic_signal = mic;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc3(input logic en, input logic load, input logic [2:0] dly,
                      input logic [7:0] mic);
    bus3.en         = en;
    bus3.load       = load;
    bus3.delay      = dly;
    bus3.fb_shift   = 3'd0;
    bus3.mic_signal = mic;
    @(posedge clk);
    #1;
  endtask

  int echo_mic [16] = '{128,128,255,128,128,128,128,128,128,128,128,255,128,255,128,128};
`ifdef ECHO_FEEDBACK_EN
  int echo_exp [16] = '{128,128,128,128,255,128,191,128,159,128,143,128,135,255,131,255};
`else
  int echo_exp [16] = '{128,128,128,128,255,128,128,128,128,128,128,128,128,255,128,255};
`endif

  initial begin
    bus9.en = 1'b0; bus9.load = 1'b0; bus9.delay = '0; bus9.fb_shift = '0; bus9.mic_signal = '0;
    bus3.en = 1'b0; bus3.load = 1'b0; bus3.delay = '0; bus3.fb_shift = '0; bus3.mic_signal = '0;

    // Reset state
    rst = 1'b0;
    cyc9(1'b0, 1'b0, 9'd0, 3'd0, 8'd0);
    cyc9(1'b0, 1'b0, 9'd0, 3'd0, 8'd0);
    check_eq("rst_out", bus9.delayed_signal, 128);
    check_eq("rst_valid", bus9.out_valid, 0);
    check_eq("rst_primed", bus9.primed, 0);

    // The first edge after reset enters RUN with a zero-delay bypass
    rst = 1'b1;
    cyc9(1'b0, 1'b0, 9'd0, 3'd0, 8'd0);
    check_eq("d0_primed", bus9.primed, 1);
    cyc9(1'b1, 1'b0, 9'd0, 3'd0, 8'd77);
    check_eq("d0_out", bus9.delayed_signal, 77);
    check_eq("d0_valid", bus9.out_valid, 1);
    cyc9(1'b0, 1'b0, 9'd0, 3'd0, 8'd0);
    check_eq("d0_valid_off", bus9.out_valid, 0);
    check_eq("d0_hold", bus9.delayed_signal, 77);

    // delay=4 with a ramp: four midpoint outputs, then a copy of the input shifted by 4
    for (int i = 0; i < 10; i++) begin
      cyc9(1'b1, (i == 0), 9'd4, 3'd0, 8'(10 + i));
      check_eq($sformatf("d4_out[%0d]", i), bus9.delayed_signal, (i < 4) ? 128 : 6 + i);
      check_eq($sformatf("d4_primed[%0d]", i), bus9.primed, (i >= 3) ? 1 : 0);
    end

    // Reload to delay=2 while running
    for (int i = 0; i < 4; i++) begin
      cyc9(1'b1, (i == 0), 9'd2, 3'd0, 8'(20 + i));
      check_eq($sformatf("rl_out[%0d]", i), bus9.delayed_signal, (i < 2) ? 128 : 18 + i);
      check_eq($sformatf("rl_primed[%0d]", i), bus9.primed, (i >= 1) ? 1 : 0);
    end

    // Gapped strobes: the delay counts samples, and the output holds between strobes
    for (int i = 0; i < 4; i++) begin
      cyc9(1'b1, 1'b0, 9'd2, 3'd0, 8'(30 + i));
      check_eq($sformatf("gap_out[%0d]", i), bus9.delayed_signal, (i == 0) ? 22 : (i == 1) ? 23 : 28 + i);
      check_eq($sformatf("gap_valid[%0d]", i), bus9.out_valid, 1);
      for (int k = 0; k < 2; k++) begin
        cyc9(1'b0, 1'b0, 9'd2, 3'd0, 8'd0);
        check_eq($sformatf("gap_idle_valid[%0d]", i), bus9.out_valid, 0);
        check_eq($sformatf("gap_hold[%0d]", i), bus9.delayed_signal, (i == 0) ? 22 : (i == 1) ? 23 : 28 + i);
      end
    end

    // Impulse into delay=2 with fb_shift=1; the expected echoes depend on the build
    for (int i = 0; i < 16; i++) begin
      cyc9(1'b1, (i == 0), 9'd2, 3'd1, 8'(echo_mic[i]));
      check_eq($sformatf("echo_out[%0d]", i), bus9.delayed_signal, echo_exp[i]);
    end

    // An A_WIDTH=3 instance at its maximum delay, with the write pointer wrapping several times
    for (int i = 0; i < 32; i++) begin
      cyc3(1'b1, (i == 0), 3'd7, 8'(i));
      check_eq($sformatf("wrap_out[%0d]", i), bus3.delayed_signal, (i < 7) ? 128 : i - 7);
    end
    cyc3(1'b0, 1'b0, 3'd7, 8'd0);

    // Reset overrides load and en, and the next edge returns to RUN
    rst = 1'b0;
    cyc9(1'b1, 1'b1, 9'd5, 3'd0, 8'd99);
    check_eq("rst2_out", bus9.delayed_signal, 128);
    check_eq("rst2_valid", bus9.out_valid, 0);
    check_eq("rst2_primed", bus9.primed, 0);
    rst = 1'b1;
    cyc9(1'b0, 1'b0, 9'd0, 3'd0, 8'd0);
    check_eq("rst2_run", bus9.primed, 1);
    cyc9(1'b1, 1'b0, 9'd0, 3'd0, 8'd42);
    check_eq("rst2_bypass", bus9.delayed_signal, 42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter A_WIDTH, default 9: address width; buffer depth is 2^A_WIDTH samples.
REQ-002 Parameter D_WIDTH, default 8: sample width, offset-binary; midpoint MID = 2^(D_WIDTH-1).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  sample strobe; one mic_signal sample accepted per cycle with en=1.
REQ-006 load  input  1  latch new delay and restart priming.
REQ-007 delay  input  A_WIDTH  requested delay in samples (0 .. 2^A_WIDTH-1); sampled only when load=1.
REQ-008 fb_shift  input  3  echo feedback attenuation (see Configuration).
REQ-009 mic_signal  input  D_WIDTH  input sample.
REQ-010 delayed_signal  output  D_WIDTH  delayed sample, registered.
REQ-011 out_valid  output  1  one-cycle pulse, asserted the cycle after each accepted sample.
REQ-012 primed  output  1  high in RUN state, i.e. buffer holds at least delay_q valid samples.

Function
REQ-013 Internal storage SHALL be a 2^A_WIDTH x D_WIDTH array with combinational read and synchronous write.
REQ-014 wr_addr SHALL advance by 1 modulo 2^A_WIDTH on each en=1; write of the sample at wr_addr on the same edge.
REQ-015 rd_addr SHALL be (wr_addr - delay_q) modulo 2^A_WIDTH, computed in A_WIDTH bits, wrap-around implicit.
REQ-016 On the edge with en=1 in RUN, delayed_signal SHALL load mem[rd_addr] as read before that edge's write, so output for sample n equals input sample n-delay_q; latency one clock.
REQ-017 delay_q=0 SHALL bypass memory: delayed_signal loads the write data of the same edge.
REQ-018 delayed_signal SHALL hold its value on cycles with en=0.
REQ-019 FSM states FILL, RUN. FILL: delayed_signal loads MID on each en, fill_cnt increments on each en. FILL->RUN when fill_cnt reaches delay_q (checked every cycle); delay_q=0 goes to RUN the cycle after load.
REQ-020 load=1 from either state SHALL latch delay_q<=delay, enter FILL, fill_cnt<=en; wr_addr and memory contents are not cleared.
REQ-021 Simultaneous load and en: sample written and counted as first fill sample; delayed_signal loads MID.
REQ-022 primed SHALL equal (state==RUN), registered.
REQ-023 Maximum delay 2^A_WIDTH-1; no full/empty flags. Overwriting the oldest sample is normal operation.

Reset
REQ-024 rst=0 at a rising edge SHALL set wr_addr=0, delay_q=0, fill_cnt=0, state=FILL, delayed_signal=MID, out_valid=0, primed=0; memory contents undefined.
REQ-025 Reset SHALL override en and load in the same cycle; reset mid-FILL or mid-RUN discards priming progress.
REQ-026 The first edge with rst=1 and no load SHALL move FILL->RUN (delay_q=0, bypass).

Configuration
REQ-027 Macro ECHO_FEEDBACK_EN. Defined: write data = saturate(mic_signal + ((mem[rd_addr] - MID) >>> fb_shift)) to 0..2^D_WIDTH-1, signed arithmetic in D_WIDTH+2 bits; fb_shift=0 disables feedback (write data = mic_signal); feedback forced off in FILL and when delay_q=0.
REQ-028 Not defined: write data = mic_signal; fb_shift port present and ignored; no adder or saturation logic synthesized.

Verification
REQ-029 Reset, load delay=4, en every cycle, mic = 10,11,12,...: four outputs equal 128, primed rises after the 4th en, fifth output = 10, then 11, 12, ...
REQ-030 delay=0 after reset, mic=77 with en: delayed_signal=77 one clock later, out_valid pulsed once.
REQ-031 A_WIDTH=3, delay=7, ramp 0..31: output tracks input minus 7 across wr_addr wrap 7->0 without glitch.
REQ-032 In RUN delay=4, pulse load with delay=2 and en together: output 128 for 2 samples, primed low then high, then samples delayed by 2.
REQ-033 en gapped (1 of 3 cycles): delay measured in samples, output holds between strobes, out_valid only after strobes.
REQ-034 ECHO_FEEDBACK_EN, delay=2, fb_shift=1, one impulse 255 then 128s: echoes 191, 159, 143, ... every 2 samples; 255+large feedback saturates at 255; without macro single echo 255 only.
